// File: rtl/wrr_pop_sequencer_pkg.sv
// Shared state encoding, default sizing and width helper for the weighted
// round-robin pop sequencer.
package wrr_pop_sequencer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } wrr_state_t;

  localparam int DEF_QUEUE_QUANTITY = 4;
  localparam int DEF_DATA_BITS      = 8;
  localparam int DEF_MAX_WEIGHT     = 64;

  // Never returns 0 so that single-entry configurations still get a 1-bit field.
  function automatic int calc_width(input int val);
    return (val > 1) ? $clog2(val) : 1;
  endfunction

endpackage

// File: rtl/wrr_pop_sequencer_next_eligible.sv
// Rotating priority search: first set bit of elig at or after start, wrapping.
module wrr_next_eligible #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  elig,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int j;
    found = 1'b0;
    idx   = start;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && elig[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wrr_pop_sequencer.sv
// Weighted round-robin FIFO pop sequencer with a two-stage output pipeline.
// Define WRR_POP_CNT_EN to add per-queue saturating pop counters (pop_cnt).
module wrr_pop_sequencer
  import wrr_pop_sequencer_pkg::*;
#(
  parameter int  QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
  parameter int  DATA_BITS      = DEF_DATA_BITS,
  parameter int  MAX_WEIGHT     = DEF_MAX_WEIGHT,
  localparam int WW             = calc_width(MAX_WEIGHT),
  localparam int QW             = calc_width(QUEUE_QUANTITY)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enb,
  input  logic [QUEUE_QUANTITY*WW-1:0]      pesos,
  input  logic [QUEUE_QUANTITY-1:0]         buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
  input  logic                              down_full,
  output logic [QUEUE_QUANTITY-1:0]         pop,
  output logic [DATA_BITS-1:0]              data_out,
  output logic                              valid_out,
  output logic [QW-1:0]                     cur_queue,
  output logic                              busy
`ifdef WRR_POP_CNT_EN
  ,
  output logic [QUEUE_QUANTITY*16-1:0]      pop_cnt
`endif
);

  wrr_state_t            state_reg;
  logic [QW-1:0]         cur_queue_reg;
  logic [WW-1:0]         credit_reg;
  logic                  busy_reg;
  logic [QUEUE_QUANTITY-1:0] elig;
  logic [QW-1:0]         search_start;
  logic [QW-1:0]         next_idx;
  logic                  next_found;
  logic [WW-1:0]         next_weight;
  logic                  run_en;
  logic                  cur_empty;
  logic                  s1_valid_reg;
  logic [QW-1:0]         s1_sel_reg;
  logic                  valid_out_reg;
  logic [DATA_BITS-1:0]  data_out_reg;

  genvar gi;

  generate
    for (gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_elig
      assign elig[gi] = !buf_empty[gi] && (pesos[gi*WW +: WW] != '0);
    end
  endgenerate

  assign run_en      = enb && !down_full;
  assign cur_empty   = buf_empty[cur_queue_reg];
  assign next_weight = pesos[next_idx*WW +: WW];

  // Entry from IDLE includes the current pointer; an advance tries it last.
  always_comb begin
    search_start = cur_queue_reg;
    if (state_reg == SERVE)
      search_start = (cur_queue_reg == QW'(QUEUE_QUANTITY-1)) ? '0 : cur_queue_reg + 1'b1;
  end

  wrr_next_eligible #(
    .N  (QUEUE_QUANTITY),
    .IW (QW)
  ) u_next (
    .start (search_start),
    .elig  (elig),
    .idx   (next_idx),
    .found (next_found)
  );

  always_comb begin
    pop = '0;
    if (state_reg == SERVE && run_en && !cur_empty && !rst)
      pop[cur_queue_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_queue_reg <= '0;
      credit_reg    <= '0;
      busy_reg      <= 1'b0;
    end else if (run_en) begin
      case (state_reg)
        IDLE: begin
          if (next_found) begin
            state_reg     <= SERVE;
            busy_reg      <= 1'b1;
            cur_queue_reg <= next_idx;
            credit_reg    <= next_weight - 1'b1;
          end
        end
        SERVE: begin
          if (cur_empty || credit_reg == '0) begin
            if (next_found) begin
              cur_queue_reg <= next_idx;
              credit_reg    <= next_weight - 1'b1;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            credit_reg <= credit_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stage 1 remembers which queue popped; its word appears on fifo_data a cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_sel_reg    <= '0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
    end else begin
      s1_valid_reg  <= |pop;
      s1_sel_reg    <= cur_queue_reg;
      valid_out_reg <= s1_valid_reg;
      if (s1_valid_reg)
        data_out_reg <= fifo_data[s1_sel_reg*DATA_BITS +: DATA_BITS];
    end
  end

  assign cur_queue = cur_queue_reg;
  assign busy      = busy_reg;
  assign valid_out = valid_out_reg;
  assign data_out  = data_out_reg;

`ifdef WRR_POP_CNT_EN
  generate
    for (gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg <= '0;
        else if (pop[gi] && cnt_reg != 16'hFFFF)
          cnt_reg <= cnt_reg + 16'd1;
      end
      assign pop_cnt[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_wrr_pop_sequencer.sv
// Scoreboard bench for wrr_pop_sequencer: FIFO environment, turn-based
// reference model, and an independent output monitor.
module tb_wrr_pop_sequencer;

  localparam int QQ = 4;
  localparam int DB = 8;
  localparam int WW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enb = 1'b0;
  logic              down_full = 1'b0;
  logic [QQ*WW-1:0]  pesos = '0;
  logic [QQ-1:0]     buf_empty = '1;
  logic [QQ*DB-1:0]  fifo_data = '0;
  logic [QQ-1:0]     pop;
  logic [DB-1:0]     data_out;
  logic              valid_out;
  logic [1:0]        cur_queue;
  logic              busy;
`ifdef WRR_POP_CNT_EN
  logic [QQ*16-1:0]  pop_cnt;
`endif

  always #5 clk = ~clk;

  wrr_pop_sequencer #(
    .QUEUE_QUANTITY (QQ),
    .DATA_BITS      (DB),
    .MAX_WEIGHT     (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .pesos     (pesos),
    .buf_empty (buf_empty),
    .fifo_data (fifo_data),
    .down_full (down_full),
    .pop       (pop),
    .data_out  (data_out),
    .valid_out (valid_out),
    .cur_queue (cur_queue),
    .busy      (busy)
`ifdef WRR_POP_CNT_EN
    ,
    .pop_cnt   (pop_cnt)
`endif
  );

  typedef struct {
    logic [DB-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DB-1:0] fq[QQ][$];
  int            w[QQ];
  int            m_cnt[QQ];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            started = 1'b0;
  logic [QQ-1:0] pend_pop = '0;
  // Model state: whether a turn is active, whose turn, and pops left in it.
  bit            m_serving = 1'b0;
  int            m_q = 0;
  int            m_left = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic int find_elig(input int start);
    for (int k = 0; k < QQ; k++) begin
      int j;
      j = (start + k) % QQ;
      if (fq[j].size() > 0 && w[j] != 0) return j;
    end
    return -1;
  endfunction

  task automatic refresh();
    for (int q = 0; q < QQ; q++) begin
      buf_empty[q]       = (fq[q].size() == 0);
      pesos[q*WW +: WW]  = WW'(w[q]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int q = 0; q < QQ; q++)
      if (pend_pop[q] && fq[q].size() > 0)
        fifo_data[q*DB +: DB] = fq[q].pop_front();
    refresh();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic fill(input int q, input int n);
    repeat (n) fq[q].push_back(DB'($urandom));
    refresh();
  endtask

  task automatic set_w(input int a, input int b, input int c, input int d);
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    refresh();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int q = 0; q < QQ; q++) fq[q].delete();
    refresh();
    run(n);
    rst = 1'b0;
  endtask

  task automatic model_step();
    logic [QQ-1:0] exp_pop;
    int nq;
    exp_pop  = '0;
    pend_pop = pop;
    if (!started) return;
    chk("busy", longint'(busy), longint'(m_serving));
    chk("cur_queue", longint'(cur_queue), longint'(m_q));
`ifdef WRR_POP_CNT_EN
    for (int q = 0; q < QQ; q++)
      chk("pop_cnt", longint'(pop_cnt[q*16 +: 16]), longint'(m_cnt[q]));
`endif
    if (rst) begin
      m_serving = 1'b0;
      m_q       = 0;
      m_left    = 0;
      sb.delete();
      for (int q = 0; q < QQ; q++) m_cnt[q] = 0;
    end else if (enb && !down_full) begin
      if (!m_serving) begin
        nq = find_elig(m_q);
        if (nq >= 0) begin
          m_serving = 1'b1;
          m_q       = nq;
          m_left    = w[nq];
        end
      end else begin
        if (fq[m_q].size() > 0) begin
          exp_pop[m_q] = 1'b1;
          sb.push_back('{data: fq[m_q][0], due: cyc + 2});
          if (m_cnt[m_q] < 16'hFFFF) m_cnt[m_q]++;
          m_left--;
        end
        if (fq[m_q].size() == 0 || m_left == 0) begin
          nq = find_elig((m_q + 1) % QQ);
          if (nq >= 0) begin
            m_q    = nq;
            m_left = w[nq];
          end else begin
            m_serving = 1'b0;
          end
        end
      end
    end
    chk("pop", longint'(pop), longint'(exp_pop));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      model_step();
    end
  end

  // Output monitor: every valid_out word must match the oldest expectation, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_valid cyc=%0d actual=none required=%0h", cyc, sb[0].data);
          void'(sb.pop_front());
        end
        if (valid_out) begin
          if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("data_out", longint'(data_out), longint'(e.data));
          end else begin
            checks++;
            failures++;
            $display("FAIL spurious_valid cyc=%0d actual=%0h required=no_word", cyc, data_out);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    for (int q = 0; q < QQ; q++) begin w[q] = 0; m_cnt[q] = 0; end
    refresh();
    cycle();
    started = 1'b1;
    run(1);
    rst = 1'b0;

    // Weights 1..4 with deep queues: steady rotation.
    set_w(1, 2, 3, 4);
    for (int q = 0; q < QQ; q++) fill(q, 20);
    enb = 1'b1;
    run(100);

    // q1 empty throughout.
    do_reset(2);
    set_w(2, 2, 2, 2);
    fill(0, 20); fill(2, 20); fill(3, 20);
    run(70);

    // Weight 0 disables q2.
    do_reset(2);
    set_w(1, 1, 0, 1);
    for (int q = 0; q < QQ; q++) fill(q, 10);
    run(40);

    // Early advance when q0 runs dry before its credit.
    do_reset(2);
    set_w(5, 1, 1, 1);
    fill(0, 2); fill(1, 5); fill(2, 5); fill(3, 5);
    run(30);

    // Backpressure in the middle of q3's turn.
    do_reset(2);
    set_w(1, 2, 3, 4);
    for (int q = 0; q < QQ; q++) fill(q, 20);
    guard = 0;
    while (!(m_serving && m_q == 3 && m_left == 3) && guard < 60) begin
      cycle();
      guard++;
    end
    down_full = 1'b1;
    run(3);
    down_full = 1'b0;
    run(80);

    // Single-cycle reset in the middle of a turn.
    do_reset(2);
    set_w(2, 2, 2, 2);
    for (int q = 0; q < QQ; q++) fill(q, 10);
    run(5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(50);

    // Randomized traffic, weight changes, backpressure and occasional reset.
    do_reset(2);
    set_w(3, 1, 2, 4);
    for (int i = 0; i < 1500; i++) begin
      enb       = ($urandom_range(0, 9) != 0);
      down_full = ($urandom_range(0, 4) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) begin
        int q;
        q = $urandom_range(0, QQ-1);
        if (fq[q].size() < 30) fill(q, $urandom_range(1, 3));
      end
      if ($urandom_range(0, 49) == 0) begin
        w[$urandom_range(0, QQ-1)] = $urandom_range(0, 8);
        refresh();
      end
      cycle();
    end
    rst       = 1'b0;
    down_full = 1'b0;
    enb       = 1'b0;
    run(6);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain cyc=%0d actual=%0d required=0 words outstanding", cyc, sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wrr_pop_sequencer.md
WRR_POP_SEQUENCER -- requirements
Module: wrr_pop_sequencer

Interface
REQ-001 Parameter QUEUE_QUANTITY, default 4, number of source FIFOs.
REQ-002 Parameter DATA_BITS, default 8, FIFO word width.
REQ-003 Parameter MAX_WEIGHT, default 64; weight field width WW = clog2(MAX_WEIGHT) = 6.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset rst, synchronous, active-high.
REQ-006 enb  input  1  scheduling enable.
REQ-007 pesos  input  QUEUE_QUANTITY*WW  per-queue weight; queue n at bits [(n+1)*WW-1 : n*WW].
REQ-008 buf_empty  input  QUEUE_QUANTITY  per-queue FIFO empty flag.
REQ-009 fifo_data  input  QUEUE_QUANTITY*DATA_BITS  per-queue FIFO read data; valid the cycle after that queue's pop.
REQ-010 down_full  input  1  downstream almost-full backpressure.
REQ-011 pop  output  QUEUE_QUANTITY  one-hot (or zero) FIFO read strobe.
REQ-012 data_out  output  DATA_BITS  registered output word.
REQ-013 valid_out  output  1  data_out qualifier, one cycle per word.
REQ-014 cur_queue  output  clog2(QUEUE_QUANTITY)  queue currently being served.
REQ-015 busy  output  1  high when state is SERVE.

Function
REQ-016 Queue q is eligible when !buf_empty[q] and weight[q] != 0; weight 0 disables q.
REQ-017 States IDLE and SERVE; registered credit counter (WW bits) and pointer cur_queue.
REQ-018 IDLE: when enb and any eligible queue exist, go to SERVE with cur_queue = first eligible queue searching upward from cur_queue (wrapping), credit = weight-1.
REQ-019 SERVE: pop[cur_queue] = enb & !down_full & !buf_empty[cur_queue] & !rst, combinational; all other pop bits 0.
REQ-020 Each pop with credit != 0 decrements credit, cur_queue unchanged.
REQ-021 Pop with credit == 0, or buf_empty[cur_queue] high in SERVE (with enb high): advance to next eligible queue after cur_queue (wrapping, cur_queue itself last), load credit = its weight-1; if none eligible go to IDLE, keep cur_queue.
REQ-022 Queue switch costs no bubble: next queue may pop the cycle after the last pop of the previous queue.
REQ-023 Weights sampled only at credit load; mid-turn weight change takes effect on the queue's next turn.
REQ-024 enb low or down_full high: no pop, state/credit/cur_queue frozen; the output pipeline still drains.
REQ-025 Pop at cycle t -> block registers fifo_data slice of popped queue at t+1 -> valid_out high and data_out stable at t+2 (latency 2, one word per pop, order preserved).
REQ-026 pop never has more than one bit set; pop never asserted for an empty queue.

Reset
REQ-027 During rst: pop = 0; next edge sets state IDLE, cur_queue 0, credit 0, valid_out 0, data_out 0, busy 0, pipeline stages cleared.
REQ-028 rst mid-SERVE discards in-flight words (no valid_out for pops issued the cycle before rst).

Configuration
REQ-029 Macro WRR_POP_CNT_EN defined: adds output pop_cnt (QUEUE_QUANTITY*16 bits), per-queue saturating-at-0xFFFF pop counters, cleared by rst.
REQ-030 WRR_POP_CNT_EN undefined: no pop_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-031 Shared package holds state encoding (IDLE, SERVE), default QUEUE_QUANTITY/DATA_BITS/MAX_WEIGHT constants and WW computation.
REQ-032 Sub-module wrr_next_eligible: combinational rotating priority search (start index, eligibility vector -> index, found flag), used for both IDLE entry and advance.

Verification
REQ-033 Weights {1,2,3,4} (q0..q3), all queues hold 20 words, down_full 0 -> pop sequence q0x1,q1x2,q2x3,q3x4 repeating, no idle cycles, valid_out matches pops 2 cycles later.
REQ-034 Weights all 2, q1 empty throughout -> sequence q0,q0,q2,q2,q3,q3 repeating; pop[1] never asserted.
REQ-035 Weight q2 = 0, others 1, all non-empty -> q2 never popped.
REQ-036 q0 weight 5 holding 2 words -> 2 pops of q0, then next cycle pops q1 (early advance on empty).
REQ-037 down_full high 3 cycles mid q3 turn, credit 2 -> no pops for 3 cycles, then remaining 3 pops of q3 resume; in-flight words still emitted.
REQ-038 rst asserted one cycle mid-SERVE -> pop 0 that cycle, next cycle busy 0, cur_queue 0, valid_out 0; with WRR_POP_CNT_EN, pop_cnt all 0.
